// File: rtl/ff_mode_pkg.sv
// Shared mode encoding and input-pair codes
// for the universal flip-flop register.
package ff_mode_pkg;

  typedef enum logic [1:0] {
    FF_D  = 2'b00,
    FF_T  = 2'b01,
    FF_JK = 2'b10,
    FF_SR = 2'b11
  } ff_mode_t;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_CLR  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_ILL  = 2'b11;

endpackage

// File: rtl/ff_next_bit.sv
// Next-state function for one flip-flop bit.
// Illegal flags S=R=1 in SR mode; the bit holds.
module ff_next_bit
  import ff_mode_pkg::*;
(
  input  ff_mode_t mode,
  input  logic     q,
  input  logic     a,
  input  logic     b,
  input  logic     en,
  output logic     q_next,
  output logic     illegal
);

  logic [1:0] w_pair;

  assign w_pair = {a, b};

  // Per-mode next state; disabled bits hold
  always_comb begin
    q_next  = q;
    illegal = 1'b0;
    if (en) begin
      unique case (mode)
        FF_D: q_next = a;
        FF_T: q_next = q ^ a;
        FF_JK: begin
          unique case (w_pair)
            JK_HOLD: q_next = q;
            JK_CLR:  q_next = 1'b0;
            JK_SET:  q_next = 1'b1;
            JK_TGL:  q_next = ~q;
            default: q_next = q;
          endcase
        end
        FF_SR: begin
          unique case (w_pair)
            SR_HOLD: q_next = q;
            SR_CLR:  q_next = 1'b0;
            SR_SET:  q_next = 1'b1;
            SR_ILL: begin
              q_next  = q;
              illegal = 1'b1;
            end
            default: q_next = q;
          endcase
        end
        default: q_next = q;
      endcase
    end
  end

endmodule

// File: rtl/universal_ff_reg.sv
// WIDTH-bit register of run-time selectable D/T/JK/SR
// flip-flops with per-bit enable and sticky SR error.
module universal_ff_reg
  import ff_mode_pkg::*;
#(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VAL    = {WIDTH{1'b0}},
  parameter logic [1:0]       DEFAULT_MODE = 2'b00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode_we,
  input  logic [1:0]       mode_in,
  input  logic             clr,
  input  logic [WIDTH-1:0] en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] q_chg,
  output logic [1:0]       mode,
  output logic [WIDTH-1:0] err_bits,
  output logic             sr_err
);

  ff_mode_t         r_mode;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_q_chg;
  logic [WIDTH-1:0] r_err;

  logic [WIDTH-1:0] w_q_bit;
  logic [WIDTH-1:0] w_ill_raw;
  logic [WIDTH-1:0] w_ill;
  logic [WIDTH-1:0] w_q_next;
  logic             w_op;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ff_next_bit u_bit (
      .mode    (r_mode),
      .q       (r_q[i]),
      .a       (a[i]),
      .b       (b[i]),
      .en      (en[i]),
      .q_next  (w_q_bit[i]),
      .illegal (w_ill_raw[i])
    );
  end

  // Per-bit operation only runs when neither clr nor a mode write
  assign w_op  = ~clr & ~mode_we;
  assign w_ill = w_ill_raw & {WIDTH{w_op}};

  // Edge priority: clr, then mode-write freeze, then per-bit op
  always_comb begin
    w_q_next = w_q_bit;
    if (clr)
      w_q_next = RESET_VAL;
    else if (mode_we)
      w_q_next = r_q;
  end

  // State registers: mode, q, change mask, sticky errors
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode  <= ff_mode_t'(DEFAULT_MODE);
      r_q     <= RESET_VAL;
      r_q_chg <= '0;
      r_err   <= '0;
    end else begin
      if (mode_we)
        r_mode <= ff_mode_t'(mode_in);
      r_q     <= w_q_next;
      r_q_chg <= w_q_next ^ r_q;
      r_err   <= (err_clr ? '0 : r_err) | w_ill;
    end
  end

  assign q        = r_q;
  assign qn       = ~r_q;
  assign q_chg    = r_q_chg;
  assign mode     = r_mode;
  assign err_bits = r_err;
  assign sr_err   = |r_err;

endmodule

// File: tb/tb_universal_ff_reg.sv
// Directed bench for universal_ff_reg, WIDTH=8.
// Inputs change after #1 past the edge; outputs checked there.
module tb_universal_ff_reg;

  logic       clk;
  logic       reset;
  logic       mode_we;
  logic [1:0] mode_in;
  logic       clr;
  logic [7:0] en;
  logic [7:0] a;
  logic [7:0] b;
  logic       err_clr;
  logic [7:0] q;
  logic [7:0] qn;
  logic [7:0] q_chg;
  logic [1:0] mode;
  logic [7:0] err_bits;
  logic       sr_err;

  int vec;
  int bad;

  universal_ff_reg #(
    .WIDTH        (8),
    .RESET_VAL    (8'h00),
    .DEFAULT_MODE (2'b00)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mode_we  (mode_we),
    .mode_in  (mode_in),
    .clr      (clr),
    .en       (en),
    .a        (a),
    .b        (b),
    .err_clr  (err_clr),
    .q        (q),
    .qn       (qn),
    .q_chg    (q_chg),
    .mode     (mode),
    .err_bits (err_bits),
    .sr_err   (sr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mode_we = 0; mode_in = 2'b00; clr = 0;
    en = 8'h00; a = 8'h00; b = 8'h00; err_clr = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 0;
    #2;
    vec++; if (q !== 8'h00) begin bad++; $display("FAIL rst_q got %h want 00", q); end
    vec++; if (qn !== 8'hFF) begin bad++; $display("FAIL rst_qn got %h want FF", qn); end
    vec++; if (mode !== 2'b00) begin bad++; $display("FAIL rst_mode got %b want 00", mode); end
    vec++; if (q_chg !== 8'h00) begin bad++; $display("FAIL rst_chg got %h want 00", q_chg); end
    vec++; if (err_bits !== 8'h00) begin bad++; $display("FAIL rst_err got %h want 00", err_bits); end
    vec++; if (sr_err !== 1'b0) begin bad++; $display("FAIL rst_srerr got %b want 0", sr_err); end
    tick();
    reset = 1;
    tick();
    // Load A5, switch to SR and record an error, then reset between edges
    en = 8'hFF; a = 8'hA5;
    tick();
    vec++; if (q !== 8'hA5) begin bad++; $display("FAIL async_load got %h want A5", q); end
    idle(); mode_we = 1; mode_in = 2'b11;
    tick();
    idle(); en = 8'hFF; a = 8'h01; b = 8'h01;
    tick();
    vec++; if (err_bits !== 8'h01) begin bad++; $display("FAIL async_preerr got %h want 01", err_bits); end
    #2;
    reset = 0;
    #1;
    vec++; if (q !== 8'h00) begin bad++; $display("FAIL async_q got %h want 00", q); end
    vec++; if (mode !== 2'b00) begin bad++; $display("FAIL async_mode got %b want 00", mode); end
    vec++; if (err_bits !== 8'h00) begin bad++; $display("FAIL async_err got %h want 00", err_bits); end
    vec++; if (sr_err !== 1'b0) begin bad++; $display("FAIL async_srerr got %b want 0", sr_err); end
    idle();
    #2;
    reset = 1;
    tick();
  endtask

  task automatic test_d_mode();
    idle(); en = 8'hFF; a = 8'h3C;
    tick();
    vec++; if (q !== 8'h3C) begin bad++; $display("FAIL d_q1 got %h want 3C", q); end
    vec++; if (q_chg !== 8'h3C) begin bad++; $display("FAIL d_chg1 got %h want 3C", q_chg); end
    vec++; if (qn !== 8'hC3) begin bad++; $display("FAIL d_qn got %h want C3", qn); end
    en = 8'h0F; a = 8'hFF;
    tick();
    vec++; if (q !== 8'h3F) begin bad++; $display("FAIL d_q2 got %h want 3F", q); end
    vec++; if (q_chg !== 8'h03) begin bad++; $display("FAIL d_chg2 got %h want 03", q_chg); end
    en = 8'h00; a = 8'h00;
    tick();
    vec++; if (q !== 8'h3F) begin bad++; $display("FAIL d_hold got %h want 3F", q); end
    vec++; if (q_chg !== 8'h00) begin bad++; $display("FAIL d_hold_chg got %h want 00", q_chg); end
    en = 8'hFF; a = 8'h3C;
    tick();
    vec++; if (q_chg !== 8'h03) begin bad++; $display("FAIL d_chg3 got %h want 03", q_chg); end
  endtask

  task automatic test_freeze_t();
    idle(); mode_we = 1; mode_in = 2'b01; en = 8'hFF; a = 8'hFF;
    tick();
    vec++; if (q !== 8'h3C) begin bad++; $display("FAIL frz_q got %h want 3C", q); end
    vec++; if (q_chg !== 8'h00) begin bad++; $display("FAIL frz_chg got %h want 00", q_chg); end
    vec++; if (mode !== 2'b01) begin bad++; $display("FAIL frz_mode got %b want 01", mode); end
    idle(); en = 8'hFF; a = 8'h0F;
    tick();
    vec++; if (q !== 8'h33) begin bad++; $display("FAIL t_q got %h want 33", q); end
    vec++; if (q_chg !== 8'h0F) begin bad++; $display("FAIL t_chg got %h want 0F", q_chg); end
  endtask

  task automatic test_jk();
    idle(); mode_we = 1; mode_in = 2'b10;
    tick();
    vec++; if (mode !== 2'b10) begin bad++; $display("FAIL jk_mode got %b want 10", mode); end
    idle(); en = 8'hFF; a = 8'hFF; b = 8'h0F;
    tick();
    vec++; if (q !== 8'hFC) begin bad++; $display("FAIL jk_q1 got %h want FC", q); end
    vec++; if (q_chg !== 8'hCF) begin bad++; $display("FAIL jk_chg1 got %h want CF", q_chg); end
    en = 8'hF0; a = 8'h00; b = 8'hF0;
    tick();
    vec++; if (q !== 8'h0C) begin bad++; $display("FAIL jk_clr got %h want 0C", q); end
    en = 8'hFF; a = 8'hF0; b = 8'h00;
    tick();
    vec++; if (q !== 8'hFC) begin bad++; $display("FAIL jk_set got %h want FC", q); end
    a = 8'h00; b = 8'h00;
    tick();
    vec++; if (q !== 8'hFC) begin bad++; $display("FAIL jk_hold got %h want FC", q); end
  endtask

  task automatic test_sr();
    idle(); mode_we = 1; mode_in = 2'b11; en = 8'hFF; a = 8'hFF; b = 8'hFF;
    tick();
    vec++; if (err_bits !== 8'h00) begin bad++; $display("FAIL sr_wr_err got %h want 00", err_bits); end
    idle(); en = 8'hFF; a = 8'h81; b = 8'h01;
    tick();
    vec++; if (q !== 8'hFC) begin bad++; $display("FAIL sr_q1 got %h want FC", q); end
    vec++; if (err_bits !== 8'h01) begin bad++; $display("FAIL sr_err1 got %h want 01", err_bits); end
    vec++; if (sr_err !== 1'b1) begin bad++; $display("FAIL sr_flag1 got %b want 1", sr_err); end
    err_clr = 1; a = 8'h02; b = 8'h02;
    tick();
    vec++; if (err_bits !== 8'h02) begin bad++; $display("FAIL sr_err2 got %h want 02", err_bits); end
    vec++; if (q !== 8'hFC) begin bad++; $display("FAIL sr_q2 got %h want FC", q); end
    a = 8'h00; b = 8'h00;
    tick();
    vec++; if (err_bits !== 8'h00) begin bad++; $display("FAIL sr_errclr got %h want 00", err_bits); end
    vec++; if (sr_err !== 1'b0) begin bad++; $display("FAIL sr_flagclr got %b want 0", sr_err); end
    err_clr = 0; en = 8'h00; a = 8'h02; b = 8'h02;
    tick();
    vec++; if (err_bits !== 8'h00) begin bad++; $display("FAIL sr_en_mask got %h want 00", err_bits); end
    en = 8'hFF;
    tick();
    vec++; if (err_bits !== 8'h02) begin bad++; $display("FAIL sr_err3 got %h want 02", err_bits); end
    a = 8'h01; b = 8'h80;
    tick();
    vec++; if (q !== 8'h7D) begin bad++; $display("FAIL sr_setclr got %h want 7D", q); end
    vec++; if (q_chg !== 8'h81) begin bad++; $display("FAIL sr_chg got %h want 81", q_chg); end
    vec++; if (err_bits !== 8'h02) begin bad++; $display("FAIL sr_sticky got %h want 02", err_bits); end
  endtask

  task automatic test_clr();
    idle(); clr = 1; mode_we = 1; mode_in = 2'b00;
    en = 8'hFF; a = 8'hFF; b = 8'hFF;
    tick();
    vec++; if (q !== 8'h00) begin bad++; $display("FAIL clr_q got %h want 00", q); end
    vec++; if (mode !== 2'b00) begin bad++; $display("FAIL clr_mode got %b want 00", mode); end
    vec++; if (err_bits !== 8'h02) begin bad++; $display("FAIL clr_err got %h want 02", err_bits); end
    vec++; if (q_chg !== 8'h7D) begin bad++; $display("FAIL clr_chg got %h want 7D", q_chg); end
  endtask

  task automatic test_back_to_back();
    idle(); en = 8'hFF; a = 8'h55;
    tick();
    vec++; if (q !== 8'h55) begin bad++; $display("FAIL b2b_d got %h want 55", q); end
    clr = 1; en = 8'h00;
    tick();
    vec++; if (q !== 8'h00) begin bad++; $display("FAIL b2b_clr got %h want 00", q); end
    vec++; if (q_chg !== 8'h55) begin bad++; $display("FAIL b2b_chg got %h want 55", q_chg); end
    clr = 0; en = 8'hFF; a = 8'hAA;
    tick();
    vec++; if (q !== 8'hAA) begin bad++; $display("FAIL b2b_d2 got %h want AA", q); end
  endtask

  initial begin
    vec = 0;
    bad = 0;
    reset = 0;
    test_reset();
    test_d_mode();
    test_freeze_t();
    test_jk();
    test_sr();
    test_clr();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
